// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-word I-cache reads and
// presents one instruction (or a NOP bubble) per cycle to the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] BOOT_PC = 32'h0000_1000,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_exception_redirect,
  input  logic [31:0] in_exception_target,
  input  logic        in_branch_taken,
  input  logic [31:0] in_branch_target,
  input  logic        in_IFID_write_disable,
  input  logic        in_d_cache_stall,
  input  logic        in_supervisor_mode,
  output logic        out_icache_req,
  output logic [31:0] out_icache_addr,
  input  logic        in_icache_valid,
  input  logic [31:0] in_icache_data,
  input  logic        in_icache_error,
  output logic [31:0] out_instruction,
  output logic [31:0] out_PC,
  output logic [2:0]  out_exception_vector,
  output logic        out_i_cache_stall,
  output logic        out_supervisor_mode,
  output logic [1:0]  out_fsm_state
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    MISS_WAIT = 2'd1,
    DISCARD   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        sup_q, sup_d;

  logic        misaligned;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        hold;
  logic        pc_update;

  // Cache handshake: out_icache_req asks for the word at out_icache_addr; the
  // cache answers with in_icache_valid in the same cycle (hit) or a later one
  // (miss), during which the request and address stay stable. There is no
  // ready back-pressure; in_icache_error is meaningful only with valid.

  assign misaligned      = (pc_q[1:0] != 2'b00);
  assign redirect        = in_exception_redirect | in_branch_taken;
  assign redirect_target = in_exception_redirect ? in_exception_target : in_branch_target;
  assign hold            = in_IFID_write_disable | in_d_cache_stall
                         | out_i_cache_stall | misaligned;
  assign pc_update       = redirect | ~hold;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        // A miss launched in a redirect cycle still owes a response; drop it.
        if (!misaligned && !in_icache_valid) begin
          state_d = redirect ? DISCARD : MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (in_icache_valid) begin
          state_d = FETCH;
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (in_icache_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    out_icache_req       = 1'b0;
    out_instruction      = NOP;
    out_i_cache_stall    = 1'b0;
    out_exception_vector = 3'b000;
    case (state_q)
      FETCH: begin
        if (misaligned) begin
          out_exception_vector = 3'b001;
        end else begin
          out_icache_req = 1'b1;
          if (in_icache_valid) begin
            out_instruction      = in_icache_data;
            out_exception_vector = {1'b0, in_icache_error, 1'b0};
          end else begin
            out_i_cache_stall = 1'b1;
          end
        end
      end
      MISS_WAIT: begin
        out_icache_req = 1'b1;
        if (in_icache_valid) begin
          out_instruction      = in_icache_data;
          out_exception_vector = {1'b0, in_icache_error, 1'b0};
        end else begin
          out_i_cache_stall = 1'b1;
        end
      end
      DISCARD: begin
        out_i_cache_stall = 1'b1;
      end
      default: begin
        out_i_cache_stall = 1'b1;
      end
    endcase
  end

  // Next PC: exception > branch > hold > sequential (wraps modulo 2^32)
  always_comb begin
    pc_d = pc_q;
    if (in_exception_redirect) begin
      pc_d = in_exception_target;
    end else if (in_branch_taken) begin
      pc_d = in_branch_target;
    end else if (!hold) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    sup_d = sup_q;
    if (pc_update) begin
      sup_d = in_supervisor_mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= BOOT_PC;
      sup_q <= 1'b1;
    end else begin
      pc_q  <= pc_d;
      sup_q <= sup_d;
    end
  end

  assign out_PC              = pc_q;
  assign out_icache_addr     = pc_q;
  assign out_supervisor_mode = sup_q;
  assign out_fsm_state       = state_q;

  // Redirect target mux is only consulted when a redirect is present.
  logic unused_target;
  assign unused_target = ^redirect_target & 1'b0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table drives the main flow,
// a scoreboard queue holds the expected outputs for each driven cycle.
module tb_fetch_stage;

  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam int EW = 102;

  logic        clk;
  logic        reset;
  logic        in_exception_redirect;
  logic [31:0] in_exception_target;
  logic        in_branch_taken;
  logic [31:0] in_branch_target;
  logic        in_IFID_write_disable;
  logic        in_d_cache_stall;
  logic        in_supervisor_mode;
  logic        out_icache_req;
  logic [31:0] out_icache_addr;
  logic        in_icache_valid;
  logic [31:0] in_icache_data;
  logic        in_icache_error;
  logic [31:0] out_instruction;
  logic [31:0] out_PC;
  logic [2:0]  out_exception_vector;
  logic        out_i_cache_stall;
  logic        out_supervisor_mode;
  logic [1:0]  out_fsm_state;

  fetch_stage #(.BOOT_PC(BOOT), .NOP(NOPI)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_exception_redirect (in_exception_redirect),
    .in_exception_target   (in_exception_target),
    .in_branch_taken       (in_branch_taken),
    .in_branch_target      (in_branch_target),
    .in_IFID_write_disable (in_IFID_write_disable),
    .in_d_cache_stall      (in_d_cache_stall),
    .in_supervisor_mode    (in_supervisor_mode),
    .out_icache_req        (out_icache_req),
    .out_icache_addr       (out_icache_addr),
    .in_icache_valid       (in_icache_valid),
    .in_icache_data        (in_icache_data),
    .in_icache_error       (in_icache_error),
    .out_instruction       (out_instruction),
    .out_PC                (out_PC),
    .out_exception_vector  (out_exception_vector),
    .out_i_cache_stall     (out_i_cache_stall),
    .out_supervisor_mode   (out_supervisor_mode),
    .out_fsm_state         (out_fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] d;
    logic        e;
    logic        br;
    logic [31:0] bt;
    logic        ex;
    logic [31:0] et;
    logic        wd;
    logic        ds;
    logic        sp;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_ins;
    logic        e_st;
    logic [2:0]  e_xv;
    logic        e_so;
  } vec_t;

  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic void add_vec(string nm, logic v, logic [31:0] d, logic e,
                                  logic br, logic [31:0] bt, logic ex, logic [31:0] et,
                                  logic wd, logic ds, logic sp,
                                  logic [31:0] pc, logic rq, logic [31:0] ins,
                                  logic st, logic [2:0] xv, logic so);
    vec_t t;
    t.nm = nm; t.v = v; t.d = d; t.e = e; t.br = br; t.bt = bt; t.ex = ex; t.et = et;
    t.wd = wd; t.ds = ds; t.sp = sp; t.e_pc = pc; t.e_req = rq; t.e_ins = ins;
    t.e_st = st; t.e_xv = xv; t.e_so = so;
    vecs.push_back(t);
  endfunction

  function automatic logic [EW-1:0] pack(logic [31:0] pc, logic rq, logic [31:0] ins,
                                          logic st, logic [2:0] xv, logic so);
    return {pc, pc, ins, rq, st, xv, so};
  endfunction

  // Driver tasks
  task automatic drive_idle();
    in_exception_redirect = 1'b0; in_exception_target = 32'h0;
    in_branch_taken = 1'b0; in_branch_target = 32'h0;
    in_IFID_write_disable = 1'b0; in_d_cache_stall = 1'b0;
    in_supervisor_mode = 1'b1;
    in_icache_valid = 1'b0; in_icache_data = 32'h0; in_icache_error = 1'b0;
  endtask

  task automatic drive_vec(input vec_t t);
    in_icache_valid = t.v; in_icache_data = t.d; in_icache_error = t.e;
    in_branch_taken = t.br; in_branch_target = t.bt;
    in_exception_redirect = t.ex; in_exception_target = t.et;
    in_IFID_write_disable = t.wd; in_d_cache_stall = t.ds;
    in_supervisor_mode = t.sp;
    exp_q.push_back(pack(t.e_pc, t.e_req, t.e_ins, t.e_st, t.e_xv, t.e_so));
  endtask

  // Scoreboard
  task automatic check(input string nm);
    logic [EW-1:0] exp_v, act_v;
    act_v = {out_PC, out_icache_addr, out_instruction, out_icache_req,
             out_i_cache_stall, out_exception_vector, out_supervisor_mode};
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got %h", nm, act_v);
      return;
    end
    exp_v = exp_q.pop_front();
    if (act_v === exp_v) pass_cnt++;
    else $display("FAIL %s: got pc=%h addr=%h ins=%h req=%b stall=%b xv=%b sup=%b, required pc=%h addr=%h ins=%h req=%b stall=%b xv=%b sup=%b",
                  nm, act_v[101:70], act_v[69:38], act_v[37:6], act_v[5], act_v[4], act_v[3:1], act_v[0],
                  exp_v[101:70], exp_v[69:38], exp_v[37:6], exp_v[5], exp_v[4], exp_v[3:1], exp_v[0]);
  endtask

  task automatic check_state(input string nm, input logic [1:0] exp_s);
    total_cnt++;
    if (out_fsm_state === exp_s) pass_cnt++;
    else $display("FAIL %s: got state=%0d required %0d", nm, out_fsm_state, exp_s);
  endtask

  initial begin
    //       name          v  data          e  br bt            ex et            wd ds sp  pc            rq ins           st xv      so
    add_vec("hit_1000",    1, 32'hA000_0000, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_1000, 1, 32'hA000_0000, 0, 3'b000, 1);
    add_vec("hit_1004",    1, 32'hA000_0001, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_1004, 1, 32'hA000_0001, 0, 3'b000, 1);
    add_vec("hit_1008",    1, 32'hA000_0002, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_1008, 1, 32'hA000_0002, 0, 3'b000, 1);
    add_vec("miss_c1",     0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_100C, 1, NOPI,          1, 3'b000, 1);
    add_vec("miss_c2",     0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_100C, 1, NOPI,          1, 3'b000, 1);
    add_vec("miss_c3",     0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_100C, 1, NOPI,          1, 3'b000, 1);
    add_vec("miss_done",   1, 32'hA000_0003, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_100C, 1, 32'hA000_0003, 0, 3'b000, 1);
    add_vec("sup_load",    1, 32'hA000_0004, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_1010, 1, 32'hA000_0004, 0, 3'b000, 1);
    add_vec("sup_user",    1, 32'hA000_0005, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_1014, 1, 32'hA000_0005, 0, 3'b000, 0);
    add_vec("hold_wdis",   1, 32'hA000_0006, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_1018, 1, 32'hA000_0006, 0, 3'b000, 0);
    add_vec("hold_dstall", 1, 32'hA000_0007, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0000_1018, 1, 32'hA000_0007, 0, 3'b000, 0);
    add_vec("hold_miss",   0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_1018, 1, NOPI,          1, 3'b000, 0);
    add_vec("hold_done",   1, 32'hA000_0008, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0000_1018, 1, 32'hA000_0008, 0, 3'b000, 0);
    add_vec("rehit",       1, 32'hA000_0008, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_1018, 1, 32'hA000_0008, 0, 3'b000, 0);
    add_vec("bmiss_c1",    0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_101C, 1, NOPI,          1, 3'b000, 0);
    add_vec("bmiss_br",    0, 32'h0,         0, 1, 32'h0000_2000, 0, 32'h0,        0, 0, 0, 32'h0000_101C, 1, NOPI,          1, 3'b000, 0);
    add_vec("disc_wait",   0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_2000, 0, NOPI,          1, 3'b000, 0);
    add_vec("disc_stale",  1, 32'hDEAD_BEEF, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_2000, 0, NOPI,          1, 3'b000, 0);
    add_vec("hit_2000",    1, 32'hB000_0000, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_2000, 1, 32'hB000_0000, 0, 3'b000, 0);
    add_vec("miss_2004",   0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_2004, 1, NOPI,          1, 3'b000, 0);
    add_vec("mw_exc",      0, 32'h0,         0, 0, 32'h0,        1, 32'h0000_0100, 0, 0, 0, 32'h0000_2004, 1, NOPI,          1, 3'b000, 0);
    add_vec("disc_redir",  0, 32'h0,         0, 1, 32'h0000_3000, 0, 32'h0,        0, 0, 0, 32'h0000_0100, 0, NOPI,          1, 3'b000, 0);
    add_vec("disc_drop",   1, 32'hDEAD_0001, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_3000, 0, NOPI,          1, 3'b000, 0);
    add_vec("exc_vs_br",   1, 32'hC000_0000, 0, 1, 32'h0000_2000, 1, 32'h0000_0100, 0, 0, 0, 32'h0000_3000, 1, 32'hC000_0000, 0, 3'b000, 0);
    add_vec("br_misalign", 1, 32'hC000_0001, 0, 1, 32'h0000_2002, 0, 32'h0,        0, 0, 0, 32'h0000_0100, 1, 32'hC000_0001, 0, 3'b000, 0);
    add_vec("misal_1",     0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_2002, 0, NOPI,          0, 3'b001, 0);
    add_vec("misal_2",     1, 32'hDEAD_0002, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_2002, 0, NOPI,          0, 3'b001, 0);
    add_vec("misal_redir", 0, 32'h0,         0, 1, 32'h0000_2010, 0, 32'h0,        0, 0, 0, 32'h0000_2002, 0, NOPI,          0, 3'b001, 0);
    add_vec("hit_err",     1, 32'hD000_0000, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_2010, 1, 32'hD000_0000, 0, 3'b010, 0);
    add_vec("sup_back",    1, 32'hD000_0001, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_2014, 1, 32'hD000_0001, 0, 3'b000, 0);
    add_vec("sup_super",   1, 32'hD000_0002, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_2018, 1, 32'hD000_0002, 0, 3'b000, 1);
    add_vec("br_top",      1, 32'hE000_0000, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 0, 1, 32'h0000_201C, 1, 32'hE000_0000, 0, 3'b000, 1);
    add_vec("pc_top",      1, 32'hE000_0001, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'hFFFF_FFFC, 1, 32'hE000_0001, 0, 3'b000, 1);
    add_vec("pc_wrap",     1, 32'hE000_0002, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0000, 1, 32'hE000_0002, 0, 3'b000, 1);
    add_vec("miss_4",      0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0004, 1, NOPI,          1, 3'b000, 1);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pack(BOOT, 1'b1, NOPI, 1'b1, 3'b000, 1'b1));
    @(negedge clk);
    check("reset_state");
    check_state("reset_fsm", 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      @(negedge clk);
      check(vecs[i].nm);
      if (vecs[i].nm == "disc_wait") check_state("discard_fsm", 2'd2);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of an outstanding miss
    drive_idle();
    check_state("miss_fsm", 2'd1);
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(pack(BOOT, 1'b1, NOPI, 1'b1, 3'b000, 1'b1));
    check("async_reset");
    check_state("async_reset_fsm", 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_icache_valid = 1'b1;
    in_icache_data  = 32'hF000_0000;
    exp_q.push_back(pack(BOOT, 1'b1, 32'hF000_0000, 1'b0, 3'b000, 1'b1));
    @(negedge clk);
    check("first_after_reset");
    @(posedge clk);
    #1;
    drive_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
